// File: rtl/cache_set_sched_pkg.sv
// Shared constants and types for the cache data-SRAM port scheduler.
package cache_set_sched_pkg;

    localparam int SET_W_DEF        = 9;
    localparam int BEATS_DEF        = 4;
    localparam int STARVE_LIMIT_DEF = 7;

    localparam logic [1:0] REQ_REFILL = 2'd0;
    localparam logic [1:0] REQ_PROBE  = 2'd1;
    localparam logic [1:0] REQ_CPU    = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/cache_set_sched_starve_counter.sv
// Saturating wait counter for one read requester; flags starvation at LIMIT.
module starve_counter
    import cache_set_sched_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    input  logic fire,
    output logic starved
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (!valid || fire) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q == CNT_MAX);

endmodule

// File: rtl/cache_set_sched.sv
// Arbitrates the single-port cache data SRAM between refill bursts, probe reads and CPU reads.
module cache_set_sched
    import cache_set_sched_pkg::*;
#(
    parameter int SET_W        = SET_W_DEF,
    parameter int BEATS        = BEATS_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_in_0_valid,
    output logic                       io_in_0_ready,
    input  logic [SET_W-1:0]           io_in_0_bits_set,
    input  logic                       io_in_1_valid,
    output logic                       io_in_1_ready,
    input  logic [SET_W-1:0]           io_in_1_bits_set,
    input  logic                       io_in_2_valid,
    output logic                       io_in_2_ready,
    input  logic [SET_W-1:0]           io_in_2_bits_set,
    output logic                       io_sram_en,
    output logic                       io_sram_wen,
    output logic [SET_W-1:0]           io_sram_set,
    output logic [$clog2(BEATS)-1:0]   io_sram_beat,
    output logic                       io_resp_valid,
    output logic [1:0]                 io_resp_id,
    output logic                       io_busy
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic                wen_q, wen_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [1:0]          rd_id_q, rd_id_d;
    logic                resp_valid_q, resp_valid_d;
    logic [1:0]          resp_id_q, resp_id_d;

    logic                starved_1, starved_2;
    logic                last_beat, port_free;
    logic                ok_0, ok_1, ok_2;
    logic [2:0]          gnt;

    // During a burst set_q still holds the burst set, so it doubles as the conflict reference.
    assign last_beat = (state_q == BURST) && (beat_q == LAST_BEAT);
    assign port_free = (state_q == IDLE);
    assign ok_0 = io_in_0_valid && port_free;
    assign ok_1 = io_in_1_valid && (port_free || (last_beat && (io_in_1_bits_set != set_q)));
    assign ok_2 = io_in_2_valid && (port_free || (last_beat && (io_in_2_bits_set != set_q)));

    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (ok_1 && starved_1)      gnt[REQ_PROBE]  = 1'b1;
            else if (ok_2 && starved_2) gnt[REQ_CPU]    = 1'b1;
            else if (ok_0)              gnt[REQ_REFILL] = 1'b1;
            else if (ok_1)              gnt[REQ_PROBE]  = 1'b1;
            else if (ok_2)              gnt[REQ_CPU]    = 1'b1;
        end
    end

    assign io_in_0_ready = gnt[REQ_REFILL];
    assign io_in_1_ready = gnt[REQ_PROBE];
    assign io_in_2_ready = gnt[REQ_CPU];

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        wen_d   = 1'b0;
        set_d   = set_q;
        beat_d  = '0;
        rd_id_d = '0;
        case (state_q)
            IDLE: begin
                if (gnt[REQ_REFILL]) begin
                    state_d = BURST;
                    en_d    = 1'b1;
                    wen_d   = 1'b1;
                    set_d   = io_in_0_bits_set;
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    en_d   = 1'b1;
                    wen_d  = 1'b1;
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A read granted in the final beat cycle issues right behind the burst.
        if (gnt[REQ_PROBE]) begin
            en_d    = 1'b1;
            set_d   = io_in_1_bits_set;
            rd_id_d = REQ_PROBE;
        end else if (gnt[REQ_CPU]) begin
            en_d    = 1'b1;
            set_d   = io_in_2_bits_set;
            rd_id_d = REQ_CPU;
        end
        resp_valid_d = en_q && !wen_q;
        resp_id_d    = resp_valid_d ? rd_id_q : 2'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            wen_q        <= 1'b0;
            set_q        <= '0;
            beat_q       <= '0;
            rd_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            wen_q        <= wen_d;
            set_q        <= set_d;
            beat_q       <= beat_d;
            rd_id_q      <= rd_id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve_1 (
        .clock   (clock),
        .reset   (reset),
        .valid   (io_in_1_valid),
        .fire    (gnt[REQ_PROBE]),
        .starved (starved_1)
    );

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve_2 (
        .clock   (clock),
        .reset   (reset),
        .valid   (io_in_2_valid),
        .fire    (gnt[REQ_CPU]),
        .starved (starved_2)
    );

    assign io_sram_en    = en_q;
    assign io_sram_wen   = wen_q;
    assign io_sram_set   = set_q;
    assign io_sram_beat  = beat_q;
    assign io_resp_valid = resp_valid_q;
    assign io_resp_id    = resp_id_q;
    assign io_busy       = (state_q == BURST);

endmodule

// File: tb/tb_cache_set_sched.sv
// Randomized and directed checks of cache_set_sched against a queue-based command model.
module tb_cache_set_sched;

    localparam int LIMIT = 7;
    localparam int NB    = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_in_0_valid, io_in_1_valid, io_in_2_valid;
    logic       io_in_0_ready, io_in_1_ready, io_in_2_ready;
    logic [8:0] io_in_0_bits_set, io_in_1_bits_set, io_in_2_bits_set;
    logic       io_sram_en, io_sram_wen;
    logic [8:0] io_sram_set;
    logic [1:0] io_sram_beat;
    logic       io_resp_valid;
    logic [1:0] io_resp_id;
    logic       io_busy;

    cache_set_sched dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_0_valid    (io_in_0_valid),
        .io_in_0_ready    (io_in_0_ready),
        .io_in_0_bits_set (io_in_0_bits_set),
        .io_in_1_valid    (io_in_1_valid),
        .io_in_1_ready    (io_in_1_ready),
        .io_in_1_bits_set (io_in_1_bits_set),
        .io_in_2_valid    (io_in_2_valid),
        .io_in_2_ready    (io_in_2_ready),
        .io_in_2_bits_set (io_in_2_bits_set),
        .io_sram_en       (io_sram_en),
        .io_sram_wen      (io_sram_wen),
        .io_sram_set      (io_sram_set),
        .io_sram_beat     (io_sram_beat),
        .io_resp_valid    (io_resp_valid),
        .io_resp_id       (io_resp_id),
        .io_busy          (io_busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       en;
        logic       wen;
        logic [8:0] set;
        logic [1:0] beat;
        logic [1:0] id;
    } cmd_t;

    // Model: the SRAM command visible this cycle plus the commands already promised for later cycles.
    cmd_t       cur;
    cmd_t       pend[$];
    logic       rsp_v;
    logic [1:0] rsp_id;
    int         wait1, wait2;

    logic       drv_rst;
    logic [2:0] drv_v;
    logic [8:0] drv_s [3];
    logic [2:0] obs_rdy;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] pick_set();
        case ($urandom_range(0, 3))
            0:       return 9'h010;
            1:       return 9'h020;
            default: return 9'($urandom_range(0, 511));
        endcase
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model, drop accepted valids.
    task automatic cycle();
        logic idle, fin, e0, e1, e2;
        logic [2:0] exp_rdy;
        int win;
        cmd_t c;
        @(negedge clock);
        reset            = drv_rst;
        io_in_0_valid    = drv_v[0];
        io_in_1_valid    = drv_v[1];
        io_in_2_valid    = drv_v[2];
        io_in_0_bits_set = drv_s[0];
        io_in_1_bits_set = drv_s[1];
        io_in_2_bits_set = drv_s[2];
        #1;
        idle = !(cur.en && cur.wen);
        fin  = cur.en && cur.wen && (pend.size() == 0);
        e0 = drv_v[0] && idle;
        e1 = drv_v[1] && (idle || (fin && drv_s[1] != cur.set));
        e2 = drv_v[2] && (idle || (fin && drv_s[2] != cur.set));
        win = -1;
        if (!drv_rst) begin
            if (e1 && wait1 == LIMIT)      win = 1;
            else if (e2 && wait2 == LIMIT) win = 2;
            else if (e0)                   win = 0;
            else if (e1)                   win = 1;
            else if (e2)                   win = 2;
        end
        exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
        obs_rdy = {io_in_2_ready, io_in_1_ready, io_in_0_ready};
        check("ready", 32'(obs_rdy), 32'(exp_rdy));
        check("ready_onehot", 32'($countones(obs_rdy) <= 1), 32'd1);
        check("sram_en", 32'(io_sram_en), 32'(cur.en));
        if (cur.en) begin
            check("sram_wen", 32'(io_sram_wen), 32'(cur.wen));
            check("sram_set", 32'(io_sram_set), 32'(cur.set));
            check("sram_beat", 32'(io_sram_beat), 32'(cur.beat));
        end
        check("busy", 32'(io_busy), 32'(cur.en && cur.wen));
        check("resp_valid", 32'(io_resp_valid), 32'(rsp_v));
        if (rsp_v) check("resp_id", 32'(io_resp_id), 32'(rsp_id));
        @(posedge clock);
        if (drv_rst) begin
            pend.delete();
            cur   = '0;
            rsp_v = 1'b0;
            wait1 = 0;
            wait2 = 0;
        end else begin
            rsp_v  = cur.en && !cur.wen;
            rsp_id = cur.id;
            if (win == 0) begin
                for (int b = 0; b < NB; b++) begin
                    c = '{en: 1'b1, wen: 1'b1, set: drv_s[0], beat: 2'(b), id: 2'd0};
                    pend.push_back(c);
                end
            end else if (win > 0) begin
                c = '{en: 1'b1, wen: 1'b0, set: drv_s[win], beat: 2'd0, id: 2'(win)};
                pend.push_back(c);
            end
            cur   = (pend.size() > 0) ? pend.pop_front() : cmd_t'('0);
            wait1 = (!drv_v[1] || win == 1) ? 0 : ((wait1 < LIMIT) ? wait1 + 1 : wait1);
            wait2 = (!drv_v[2] || win == 2) ? 0 : ((wait2 < LIMIT) ? wait2 + 1 : wait2);
            if (win >= 0) drv_v[win] = 1'b0;
        end
    endtask

    initial begin
        logic served;
        cur = '0; rsp_v = 1'b0; rsp_id = '0; wait1 = 0; wait2 = 0;
        drv_rst = 1'b1; drv_v = '0;
        for (int i = 0; i < 3; i++) drv_s[i] = '0;
        repeat (3) cycle();
        drv_rst = 1'b0;
        repeat (2) cycle();

        // Single CPU read
        drv_v[2] = 1'b1; drv_s[2] = 9'h005;
        cycle();
        check("cpu_ready_t0", 32'(obs_rdy), 32'b100);
        #1;
        check("cpu_en_t1", 32'(io_sram_en), 32'd1);
        check("cpu_wen_t1", 32'(io_sram_wen), 32'd0);
        check("cpu_set_t1", 32'(io_sram_set), 32'h005);
        cycle();
        #1;
        check("cpu_resp_t2", 32'(io_resp_valid), 32'd1);
        check("cpu_id_t2", 32'(io_resp_id), 32'd2);
        repeat (3) cycle();

        // Refill beats a pending probe to a different set; probe slips into the last beat cycle
        drv_v[0] = 1'b1; drv_s[0] = 9'h010;
        drv_v[1] = 1'b1; drv_s[1] = 9'h020;
        cycle();
        check("refill_wins_t0", 32'(obs_rdy), 32'b001);
        repeat (4) cycle();
        check("probe_ready_t4", 32'(obs_rdy), 32'b010);
        #1;
        check("probe_en_t5", 32'(io_sram_en), 32'd1);
        check("probe_wen_t5", 32'(io_sram_wen), 32'd0);
        check("probe_set_t5", 32'(io_sram_set), 32'h020);
        cycle();
        #1;
        check("probe_resp_id_t6", 32'(io_resp_id), 32'd1);
        repeat (3) cycle();

        // Probe to the set being refilled waits for the burst to end
        drv_v[0] = 1'b1; drv_s[0] = 9'h010;
        drv_v[1] = 1'b1; drv_s[1] = 9'h010;
        cycle();
        for (int i = 0; i < NB; i++) begin
            cycle();
            check("conflict_probe_blocked", 32'(obs_rdy[1]), 32'd0);
        end
        cycle();
        check("conflict_probe_idle", 32'(obs_rdy), 32'b010);
        #1;
        check("conflict_probe_set", 32'(io_sram_set), 32'h010);
        repeat (3) cycle();

        // Two reads together: probe first, CPU next
        drv_v[1] = 1'b1; drv_s[1] = 9'h055;
        drv_v[2] = 1'b1; drv_s[2] = 9'h066;
        cycle();
        check("both_reads_first", 32'(obs_rdy), 32'b010);
        cycle();
        check("both_reads_second", 32'(obs_rdy), 32'b100);
        repeat (3) cycle();

        // Back-to-back refills with a conflicting CPU read: CPU eventually wins by starvation
        served = 1'b0;
        drv_v[2] = 1'b1; drv_s[2] = 9'h030;
        for (int i = 0; i < 40; i++) begin
            drv_v[0] = 1'b1; drv_s[0] = 9'h030;
            cycle();
            if (obs_rdy[2]) served = 1'b1;
        end
        check("starved_cpu_served", 32'(served), 32'd1);
        drv_v = '0;
        repeat (6) cycle();

        // Reset at beat 1 abandons the burst; the pending refill restarts at beat 0
        drv_v[0] = 1'b1; drv_s[0] = 9'h040;
        repeat (2) cycle();
        drv_rst = 1'b1; drv_v[0] = 1'b1;
        cycle();
        check("rst_ready", 32'(obs_rdy), 32'b000);
        #1;
        check("rst_sram_en", 32'(io_sram_en), 32'd0);
        check("rst_busy", 32'(io_busy), 32'd0);
        drv_rst = 1'b0;
        cycle();
        #1;
        check("restart_wen", 32'(io_sram_wen), 32'd1);
        check("restart_beat", 32'(io_sram_beat), 32'd0);
        check("restart_set", 32'(io_sram_set), 32'h040);
        repeat (6) cycle();

        // Random traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if (!drv_v[0] && $urandom_range(0, 5) == 0) begin
                drv_v[0] = 1'b1; drv_s[0] = pick_set();
            end
            for (int r = 1; r < 3; r++) begin
                if (!drv_v[r] && $urandom_range(0, 3) == 0) begin
                    drv_v[r] = 1'b1; drv_s[r] = pick_set();
                end
            end
            drv_rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        drv_rst = 1'b0;
        drv_v = '0;
        repeat (8) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
